sbox_pipe: RTL and testbench

SBOX_PIPE -- requirements
Module: sbox_pipe

---
 rtl/sbox_pkg.sv | 45 ++++
 rtl/sbox_lane.sv | 13 +
 rtl/sbox_pipe.sv | 111 +++++++++++
 tb/tb_sbox_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// Shared constants for the byte-substitution pipeline: lane width and the
// forward / inverse AES substitution tables.
package sbox_pkg;

  localparam int LANE_W = 8;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of substitution: purely combinational table lookup,
// forward or inverse selected by inv.
module sbox_lane
  import sbox_pkg::*;
(
  input  logic [LANE_W-1:0] in_byte,
  input  logic              inv,
  output logic [LANE_W-1:0] out_byte
);

  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sbox_pipe.sv
// Two-stage valid/ready pipeline applying forward or inverse AES byte
// substitution to LANES bytes per beat, with a sideband tag and delivered-beat counter.
module sbox_pipe
  import sbox_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W*LANES-1:0] in_data,
  input  logic                    in_inv,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [15:0]             beat_count
);

  localparam int DW = LANE_W * LANES;

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic             s1_inv_q, s1_inv_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [15:0]      beat_count_q, beat_count_d;

  logic [DW-1:0]    sub_data;
  logic             in_fire;
  logic             s2_load;
  logic             out_fire;

  // Substitution sits between S1 and S2 so S1 holds the raw captured beat.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sbox_lane u_lane (
        .in_byte  (s1_data_q[gi*LANE_W +: LANE_W]),
        .inv      (s1_inv_q),
        .out_byte (sub_data[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_inv_d     = s1_inv_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_tag_d     = s2_tag_q;
    beat_count_d = beat_count_q + 16'(out_fire);

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_inv_d   = in_inv;
      s1_tag_d   = in_tag;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = sub_data;
      s2_tag_d   = s1_tag_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_tag_q     <= '0;
      beat_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_tag_q     <= s2_tag_d;
      beat_count_q <= beat_count_d;
    end
  end

  // S1 payload is only meaningful while s1_valid_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    s1_inv_q  <= s1_inv_d;
    s1_tag_q  <= s1_tag_d;
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_tag    = s2_tag_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_sbox_pipe.sv
// Scoreboard bench for sbox_pipe: reference tables are derived from GF(2^8)
// arithmetic, expected beats are queued on input transfer and checked on output transfer.
module tb_sbox_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int DW    = 8 * LANES;
  localparam int BOUND = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             in_inv = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      beat_count;

  always #5 clk = ~clk;

  sbox_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inv     (in_inv),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .beat_count (beat_count)
  );

  typedef struct {
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  logic [7:0]       sbox_m [256];
  logic [7:0]       isbox_m [256];
  bit               rand_ready = 1'b0;
  bit               junk = 1'b0;
  logic [15:0]      exp_count = '0;
  bit               prev_stall = 1'b0;
  logic [DW-1:0]    prev_data = '0;
  logic [TAG_W-1:0] prev_tag = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] x, iv, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      iv = '0;
      if (i != 0) begin
        for (int j = 1; j < 256; j++) begin
          if (gmul(x, 8'(j)) == 8'h01) iv = 8'(j);
        end
      end
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      sbox_m[i] = s;
      isbox_m[s] = x;
    end
  endtask

  function automatic logic [DW-1:0] subst(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      b = d[l*8 +: 8];
      r[l*8 +: 8] = inv ? isbox_m[b] : sbox_m[b];
    end
    return r;
  endfunction

  // Monitor: handshake model, counter model, stall stability and in-order delivery.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_count = '0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
      check("beat_count", 64'(beat_count), 64'(exp_count));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        check("beat_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
        exp_count = exp_count + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] data, input logic inv, input logic [TAG_W-1:0] tag);
    bit fired;
    int tries;
    exp_t e;
    fired = 1'b0;
    tries = 0;
    in_valid = 1'b1; in_data = data; in_inv = inv; in_tag = tag;
    while (!fired && tries < BOUND) begin
      @(negedge clk);
      if (in_ready) begin
        fired = 1'b1;
        #1;
        e.data = subst(data, inv);
        e.tag  = tag;
        sb.push_back(e);
      end else if (junk) begin
        in_data = ~data;
        in_tag  = ~tag;
      end
      @(posedge clk); #1;
      in_data = data;
      in_tag  = tag;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tries++;
    end
    check("send_accepted", 64'(fired), 64'(1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    out_ready = 1'b1;
    while (sb.size() != 0 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic latency_check(input logic [DW-1:0] data, input logic inv,
                               input logic [TAG_W-1:0] tag, input logic [DW-1:0] exp);
    drain();
    send(data, inv, tag);
    idle();
    @(negedge clk);
    check("latency_cycle1_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("latency_cycle2_valid", 64'(out_valid), 64'(1));
    check("known_vector_data", 64'(out_data), 64'(exp));
    check("known_vector_tag", 64'(out_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  initial begin
    int start;
    logic [7:0] b;
    build_tables();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_beat_count", 64'(beat_count), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_out_tag", 64'(out_tag), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    latency_check(32'hFF53_0100, 1'b0, 4'h5, 32'h16ED_7C63);
    latency_check(32'h16ED_7C63, 1'b1, 4'hA, 32'hFF53_0100);

    // Alternating mode, back-to-back
    drain();
    start = cyc;
    for (int i = 0; i < 8; i++) send($urandom, i[0], i[TAG_W-1:0]);
    check("alternating_throughput", 64'(cyc - start), 64'(8));
    drain();

    // All bytes forward, then their images inverse (round trip)
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send({b, ~b, b ^ 8'h5a, b}, 1'b0, b[TAG_W-1:0]);
    end
    for (int i = 0; i < 256; i++) begin
      b = sbox_m[i];
      send({b, 8'(i), ~b, b}, 1'b1, b[TAG_W-1:0]);
    end
    drain();

    // Random backpressure with out-of-protocol input wiggle while stalled
    rand_ready = 1'b1;
    junk = 1'b1;
    for (int i = 0; i < 1000; i++) send($urandom, 1'($urandom_range(0, 1)), i[TAG_W-1:0]);
    rand_ready = 1'b0;
    junk = 1'b0;
    drain();

    // Fill both stages, then simultaneous in/out transfer while full
    out_ready = 1'b0;
    send(32'h0011_2233, 1'b0, 4'h1);
    send(32'h4455_6677, 1'b1, 4'h2);
    idle();
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    start = cyc;
    send(32'h8899_AABB, 1'b0, 4'h3);
    check("full_pass_through_cycles", 64'(cyc - start), 64'(1));
    idle();
    out_ready = 1'b0;

    // Reset with two beats in flight
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_beat_count", 64'(beat_count), 64'(0));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_out_tag", 64'(out_tag), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("midrst_no_stale", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // Counter wrap after 65536 deliveries
    for (int i = 0; i < 65536; i++) send($urandom, i[0], i[TAG_W-1:0]);
    drain();
    @(negedge clk);
    check("beat_count_wrap", 64'(beat_count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
